// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//   Architectural PC register for the single-cycle MIPS datapath. Captures
//   the next-PC mux output on every rising clock edge. It also provides the
//   PC+4 value and a word-misalignment flag, so downstream logic does not
//   recompute them.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset (0 = in reset)
//   nextPC      in   WIDTH  next instruction address from the next-PC mux
//   currentPC   out  WIDTH  registered current instruction address
//   pcPlus4     out  WIDTH  currentPC + 4, combinational, wraps modulo 2^WIDTH
//   misaligned  out  1      currentPC[1:0] != 0, combinational
// ---------------------------------------------------------------------------
module program_counter #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] nextPC,
  output logic [WIDTH-1:0] currentPC,
  output logic [WIDTH-1:0] pcPlus4,
  output logic             misaligned
);

  localparam int unsigned INSTR_BYTES = 4;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // No enable or stall: the register loads the mux output every cycle, unmasked.
  always_comb begin
    pc_d = nextPC;
  end

  // The async clear forces RESET_VECTOR immediately. An edge that coincides
  // with reset release still sees reset low, so it keeps the vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign currentPC  = pc_q;
  // The adder drops the carry out, so the value wraps silently.
  assign pcPlus4    = pc_q + WIDTH'(INSTR_BYTES);
  assign misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] nextPC;
  logic [WIDTH-1:0] currentPC;
  logic [WIDTH-1:0] pcPlus4;
  logic             misaligned;

  int total;
  int bad;

  program_counter #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .nextPC     (nextPC),
    .currentPC  (currentPC),
    .pcPlus4    (pcPlus4),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async reset before any clock edge, then held through a clock edge.
  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++;
    if (currentPC !== 32'h0000_0000) begin
      bad++; $display("FAIL reset_pc got=%h exp=%h", currentPC, 32'h0000_0000);
    end
    total++;
    if (pcPlus4 !== 32'h0000_0004) begin
      bad++; $display("FAIL reset_pc4 got=%h exp=%h", pcPlus4, 32'h0000_0004);
    end
    total++;
    if (misaligned !== 1'b0) begin
      bad++; $display("FAIL reset_mis got=%b exp=%b", misaligned, 1'b0);
    end
    nextPC = 32'h0000_0040;
    @(posedge clk); #1;
    total++;
    if (currentPC !== 32'h0000_0000) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", currentPC, 32'h0000_0000);
    end
  endtask

  // Normal sequential loading, one-cycle latency.
  task automatic test_load();
    @(negedge clk);
    reset  = 1'b1;
    nextPC = 32'h0000_0004;
    @(posedge clk); #1;
    total++;
    if (currentPC !== 32'h0000_0004) begin
      bad++; $display("FAIL load1_pc got=%h exp=%h", currentPC, 32'h0000_0004);
    end
    total++;
    if (pcPlus4 !== 32'h0000_0008) begin
      bad++; $display("FAIL load1_pc4 got=%h exp=%h", pcPlus4, 32'h0000_0008);
    end
    @(negedge clk);
    nextPC = 32'h0000_0008;
    @(posedge clk); #1;
    total++;
    if (currentPC !== 32'h0000_0008) begin
      bad++; $display("FAIL load2_pc got=%h exp=%h", currentPC, 32'h0000_0008);
    end
  endtask

  // Reset asserted between edges overrides the pending nextPC at once.
  task automatic test_mid_reset();
    @(negedge clk);
    nextPC = 32'h0000_0010;
    #2 reset = 1'b0;
    #1;
    total++;
    if (currentPC !== 32'h0000_0000) begin
      bad++; $display("FAIL midrst_pc got=%h exp=%h", currentPC, 32'h0000_0000);
    end
    total++;
    if (pcPlus4 !== 32'h0000_0004) begin
      bad++; $display("FAIL midrst_pc4 got=%h exp=%h", pcPlus4, 32'h0000_0004);
    end
    @(posedge clk); #1;
    total++;
    if (currentPC !== 32'h0000_0000) begin
      bad++; $display("FAIL midrst_hold got=%h exp=%h", currentPC, 32'h0000_0000);
    end
  endtask

  // Releasing reset does not load anything until the next rising edge.
  task automatic test_release();
    @(negedge clk);
    reset  = 1'b1;
    nextPC = 32'h0000_0010;
    #1;
    total++;
    if (currentPC !== 32'h0000_0000) begin
      bad++; $display("FAIL release_noupd got=%h exp=%h", currentPC, 32'h0000_0000);
    end
    @(posedge clk); #1;
    total++;
    if (currentPC !== 32'h0000_0010) begin
      bad++; $display("FAIL release_load got=%h exp=%h", currentPC, 32'h0000_0010);
    end
  endtask

  // PC+4 wraps modulo 2^32.
  task automatic test_wrap();
    @(negedge clk);
    nextPC = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    total++;
    if (currentPC !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_pc got=%h exp=%h", currentPC, 32'hFFFF_FFFC);
    end
    total++;
    if (pcPlus4 !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_pc4 got=%h exp=%h", pcPlus4, 32'h0000_0000);
    end
    total++;
    if (misaligned !== 1'b0) begin
      bad++; $display("FAIL wrap_mis got=%b exp=%b", misaligned, 1'b0);
    end
  endtask

  // Misaligned addresses are stored unmasked and flagged.
  task automatic test_misaligned();
    logic [WIDTH-1:0] pcs [5]  = '{32'h0000_0006, 32'h0000_000C, 32'h0000_0003,
                                   32'h8000_0001, 32'hFFFF_FFFE};
    logic [WIDTH-1:0] p4s [5]  = '{32'h0000_000A, 32'h0000_0010, 32'h0000_0007,
                                   32'h8000_0005, 32'h0000_0002};
    logic             mis [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nextPC = pcs[i];
      @(posedge clk); #1;
      total++;
      if (currentPC !== pcs[i]) begin
        bad++; $display("FAIL mis_pc[%0d] got=%h exp=%h", i, currentPC, pcs[i]);
      end
      total++;
      if (pcPlus4 !== p4s[i]) begin
        bad++; $display("FAIL mis_pc4[%0d] got=%h exp=%h", i, pcPlus4, p4s[i]);
      end
      total++;
      if (misaligned !== mis[i]) begin
        bad++; $display("FAIL mis_flag[%0d] got=%b exp=%b", i, misaligned, mis[i]);
      end
    end
  endtask

  // Consecutive edges each load a new, unrelated value (no hold/stall).
  task automatic test_back_to_back();
    logic [WIDTH-1:0] seq [6] = '{32'h0040_0000, 32'h0040_0004, 32'h1234_5678,
                                  32'hDEAD_BEEC, 32'h0000_0000, 32'h7FFF_FFFC};
    logic [WIDTH-1:0] seq4 [6] = '{32'h0040_0004, 32'h0040_0008, 32'h1234_567C,
                                   32'hDEAD_BEF0, 32'h0000_0004, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (i > 0 && currentPC !== seq[i-1]) begin
        bad++; $display("FAIL b2b_prev[%0d] got=%h exp=%h", i, currentPC, seq[i-1]);
      end
      nextPC = seq[i];
      @(posedge clk); #1;
      total++;
      if (currentPC !== seq[i]) begin
        bad++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, currentPC, seq[i]);
      end
      total++;
      if (pcPlus4 !== seq4[i]) begin
        bad++; $display("FAIL b2b_pc4[%0d] got=%h exp=%h", i, pcPlus4, seq4[i]);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    nextPC = 32'h0000_0000;
    test_reset();
    test_load();
    test_mid_reset();
    test_release();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
